ctrl_pipeline: RTL and testbench

Control-signal pipeline for the Filter-GPU core's control unit. It carries decode-generated control bits through the Decode/Execute, Execute/Memory and Memory/Writeback boundaries. It feeds the unqualified Execute-stage controls into the condition logic and captures that logic's qualified outputs (RegWrite, MemWrite, PCSrc) for the Memory and Writeback stages. It also owns bubble insertion on stall and flush, plus the PC-write-pending and load-use hazard indications used by the hazard unit.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/ctrl_stage_reg.sv | 29 ++
 rtl/ctrl_pipeline.sv | 152 +++++++++++++++
 tb/tb_ctrl_pipeline.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Control-record types carried across the D/E, E/M and M/W boundaries,
// their bubble values, and the load-use compare shared by the hazard output.
package ctrl_pkg;

  localparam int CTRL_REGADDR_W = 4;

  typedef struct packed {
    logic                      PCS;
    logic                      RegW;
    logic                      MemW;
    logic                      MemtoReg;
    logic                      B;
    logic                      NoWrite;
    logic [1:0]                FlagW;
    logic [3:0]                Cond;
    logic [CTRL_REGADDR_W-1:0] WA3;
  } ctrl_de_t;

  typedef struct packed {
    logic                      RegWrite;
    logic                      MemWrite;
    logic                      MemtoReg;
    logic                      PCSrc;
    logic                      PCS;
    logic [CTRL_REGADDR_W-1:0] WA3;
  } ctrl_em_t;

  typedef struct packed {
    logic                      RegWrite;
    logic                      MemtoReg;
    logic                      PCSrc;
    logic [CTRL_REGADDR_W-1:0] WA3;
  } ctrl_mw_t;

  // A bubble has every write enable low, which is what makes it inert.
  localparam ctrl_de_t CTRL_DE_BUBBLE = '0;
  localparam ctrl_em_t CTRL_EM_BUBBLE = '0;
  localparam ctrl_mw_t CTRL_MW_BUBBLE = '0;

  function automatic logic ld_use_hit(
    input ctrl_de_t                  e,
    input logic [CTRL_REGADDR_W-1:0] ra1,
    input logic [CTRL_REGADDR_W-1:0] ra2
  );
    return e.MemtoReg & e.RegW & ((e.WA3 == ra1) | (e.WA3 == ra2));
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Pipeline boundary register: async active-low reset, synchronous clear to the
// bubble value (clear wins over enable), otherwise load when enabled.
module ctrl_stage_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= CLR_VAL;
    end else if (i_clr) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-signal pipeline through D/E, E/M and M/W with bubble insertion on
// stall/flush, plus the PC-write-pending and load-use hazard indications.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REGADDR_W = CTRL_REGADDR_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 PCSD,
  input  logic                 RegWD,
  input  logic                 MemWD,
  input  logic                 MemtoRegD,
  input  logic                 BD,
  input  logic                 NoWriteD,
  input  logic [1:0]           FlagWD,
  input  logic [3:0]           CondD,
  input  logic [REGADDR_W-1:0] WA3D,
  input  logic [REGADDR_W-1:0] RA1D,
  input  logic [REGADDR_W-1:0] RA2D,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 PCSrcE,
  output logic                 PCSE,
  output logic                 RegWE,
  output logic                 MemWE,
  output logic                 MemtoRegE,
  output logic                 BE,
  output logic                 NoWriteE,
  output logic [1:0]           FlagWE,
  output logic [3:0]           CondE,
  output logic [REGADDR_W-1:0] WA3E,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 MemtoRegM,
  output logic                 PCSrcM,
  output logic [REGADDR_W-1:0] WA3M,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic [REGADDR_W-1:0] WA3W,
  output logic                 PCWrPendingF,
  output logic                 LdStallD
);

  ctrl_de_t w_de_d;
  ctrl_de_t r_de;
  ctrl_em_t w_em_d;
  ctrl_em_t r_em;
  ctrl_mw_t w_mw_d;
  ctrl_mw_t r_mw;
  logic     w_de_en;

  always_comb begin
    w_de_d          = CTRL_DE_BUBBLE;
    w_de_d.PCS      = PCSD;
    w_de_d.RegW     = RegWD;
    w_de_d.MemW     = MemWD;
    w_de_d.MemtoReg = MemtoRegD;
    w_de_d.B        = BD;
    w_de_d.NoWrite  = NoWriteD;
    w_de_d.FlagW    = FlagWD;
    w_de_d.Cond     = CondD;
    w_de_d.WA3      = WA3D;
  end

  // E/M takes the condition-qualified enables, never the raw RegW/MemW.
  always_comb begin
    w_em_d          = CTRL_EM_BUBBLE;
    w_em_d.RegWrite = RegWriteE;
    w_em_d.MemWrite = MemWriteE;
    w_em_d.MemtoReg = r_de.MemtoReg;
    w_em_d.PCSrc    = PCSrcE;
    w_em_d.PCS      = r_de.PCS;
    w_em_d.WA3      = r_de.WA3;
  end

  always_comb begin
    w_mw_d          = CTRL_MW_BUBBLE;
    w_mw_d.RegWrite = r_em.RegWrite;
    w_mw_d.MemtoReg = r_em.MemtoReg;
    w_mw_d.PCSrc    = r_em.PCSrc;
    w_mw_d.WA3      = r_em.WA3;
  end

  assign w_de_en = ~StallE;

  ctrl_stage_reg #(
    .W       ($bits(ctrl_de_t)),
    .CLR_VAL (CTRL_DE_BUBBLE)
  ) u_de_reg (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_en    (w_de_en),
    .i_clr   (FlushE),
    .i_d     (w_de_d),
    .o_q     (r_de)
  );

  // A stalled instruction stays in E, so E/M must see a bubble to avoid a duplicate.
  ctrl_stage_reg #(
    .W       ($bits(ctrl_em_t)),
    .CLR_VAL (CTRL_EM_BUBBLE)
  ) u_em_reg (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_en    (1'b1),
    .i_clr   (StallE),
    .i_d     (w_em_d),
    .o_q     (r_em)
  );

  ctrl_stage_reg #(
    .W       ($bits(ctrl_mw_t)),
    .CLR_VAL (CTRL_MW_BUBBLE)
  ) u_mw_reg (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_en    (1'b1),
    .i_clr   (1'b0),
    .i_d     (w_mw_d),
    .o_q     (r_mw)
  );

  // E outputs come straight off the register: the condition logic samples them mid-cycle.
  assign PCSE      = r_de.PCS;
  assign RegWE     = r_de.RegW;
  assign MemWE     = r_de.MemW;
  assign MemtoRegE = r_de.MemtoReg;
  assign BE        = r_de.B;
  assign NoWriteE  = r_de.NoWrite;
  assign FlagWE    = r_de.FlagW;
  assign CondE     = r_de.Cond;
  assign WA3E      = r_de.WA3;

  assign RegWriteM = r_em.RegWrite;
  assign MemWriteM = r_em.MemWrite;
  assign MemtoRegM = r_em.MemtoReg;
  assign PCSrcM    = r_em.PCSrc;
  assign WA3M      = r_em.WA3;

  assign RegWriteW = r_mw.RegWrite;
  assign MemtoRegW = r_mw.MemtoReg;
  assign PCSrcW    = r_mw.PCSrc;
  assign WA3W      = r_mw.WA3;

  assign PCWrPendingF = PCSD | r_de.PCS | r_em.PCS;
  assign LdStallD     = ld_use_hit(r_de, RA1D, RA2D);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an instruction-record model.
module tb_ctrl_pipeline;

  localparam int AW = 4;

  logic          CLK;
  logic          RST;
  logic          StallE, FlushE;
  logic          PCSD, RegWD, MemWD, MemtoRegD, BD, NoWriteD;
  logic [1:0]    FlagWD;
  logic [3:0]    CondD;
  logic [AW-1:0] WA3D, RA1D, RA2D;
  logic          RegWriteE, MemWriteE, PCSrcE;
  logic          PCSE, RegWE, MemWE, MemtoRegE, BE, NoWriteE;
  logic [1:0]    FlagWE;
  logic [3:0]    CondE;
  logic [AW-1:0] WA3E;
  logic          RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [AW-1:0] WA3M;
  logic          RegWriteW, MemtoRegW, PCSrcW;
  logic [AW-1:0] WA3W;
  logic          PCWrPendingF, LdStallD;

  ctrl_pipeline #(.REGADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE),
    .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD), .MemtoRegD(MemtoRegD),
    .BD(BD), .NoWriteD(NoWriteD), .FlagWD(FlagWD), .CondD(CondD),
    .WA3D(WA3D), .RA1D(RA1D), .RA2D(RA2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .MemtoRegE(MemtoRegE),
    .BE(BE), .NoWriteE(NoWriteE), .FlagWE(FlagWE), .CondE(CondE), .WA3E(WA3E),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .WA3M(WA3M),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
    .PCWrPendingF(PCWrPendingF), .LdStallD(LdStallD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction records as they sit in Execute, Memory and Writeback.
  typedef struct packed {
    logic pcs, regw, memw, memtoreg, b, nowrite;
    logic [1:0] flagw;
    logic [3:0] cond;
    logic [AW-1:0] wa3;
  } e_rec_t;

  typedef struct packed {
    logic regwrite, memwrite, memtoreg, pcsrc, pcs;
    logic [AW-1:0] wa3;
  } m_rec_t;

  e_rec_t m_e = '0;
  m_rec_t m_m = '0;
  m_rec_t m_w = '0;
  int     checks = 0;
  int     errors = 0;
  bit     cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_e();
    return {PCSE, RegWE, MemWE, MemtoRegE, BE, NoWriteE, FlagWE, CondE, WA3E};
  endfunction

  function automatic logic [7:0] dut_m();
    return {RegWriteM, MemWriteM, MemtoRegM, PCSrcM, WA3M};
  endfunction

  function automatic logic [6:0] dut_w();
    return {RegWriteW, MemtoRegW, PCSrcW, WA3W};
  endfunction

  // Reference: each edge every record moves one stage on. A stall keeps the
  // Execute record and sends nothing onward; a flush empties Execute.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_e = '0;
      m_m = '0;
      m_w = '0;
    end else begin
      m_w = m_m;
      if (StallE) begin
        m_m = '0;
      end else begin
        m_m.regwrite = RegWriteE;
        m_m.memwrite = MemWriteE;
        m_m.memtoreg = m_e.memtoreg;
        m_m.pcsrc    = PCSrcE;
        m_m.pcs      = m_e.pcs;
        m_m.wa3      = m_e.wa3;
      end
      if (FlushE) begin
        m_e = '0;
      end else if (!StallE) begin
        m_e.pcs      = PCSD;
        m_e.regw     = RegWD;
        m_e.memw     = MemWD;
        m_e.memtoreg = MemtoRegD;
        m_e.b        = BD;
        m_e.nowrite  = NoWriteD;
        m_e.flagw    = FlagWD;
        m_e.cond     = CondD;
        m_e.wa3      = WA3D;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("E stage", 32'(dut_e()), 32'(m_e));
      chk("M stage", 32'(dut_m()),
          32'({m_m.regwrite, m_m.memwrite, m_m.memtoreg, m_m.pcsrc, m_m.wa3}));
      chk("W stage", 32'(dut_w()), 32'({m_w.regwrite, m_w.memtoreg, m_w.pcsrc, m_w.wa3}));
      chk("PCWrPendingF", 32'(PCWrPendingF), 32'(PCSD | m_e.pcs | m_m.pcs));
      chk("LdStallD", 32'(LdStallD),
          32'(m_e.memtoreg & m_e.regw & ((m_e.wa3 == RA1D) | (m_e.wa3 == RA2D))));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    StallE = 0; FlushE = 0;
    PCSD = 0; RegWD = 0; MemWD = 0; MemtoRegD = 0; BD = 0; NoWriteD = 0;
    FlagWD = '0; CondD = '0; WA3D = '0; RA1D = '0; RA2D = '0;
    RegWriteE = 0; MemWriteE = 0; PCSrcE = 0;
  endtask

  task automatic rand_inputs();
    StallE    = ($urandom_range(0, 4) == 0);
    FlushE    = ($urandom_range(0, 6) == 0);
    PCSD      = 1'($urandom);
    RegWD     = 1'($urandom);
    MemWD     = 1'($urandom);
    MemtoRegD = 1'($urandom);
    BD        = 1'($urandom);
    NoWriteD  = 1'($urandom);
    FlagWD    = 2'($urandom);
    CondD     = 4'($urandom);
    WA3D      = AW'($urandom);
    RA1D      = ($urandom_range(0, 3) == 0) ? m_e.wa3 : AW'($urandom);
    RA2D      = ($urandom_range(0, 3) == 0) ? m_e.wa3 : AW'($urandom);
    RegWriteE = 1'($urandom);
    MemWriteE = 1'($urandom);
    PCSrcE    = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    idle();
    #1 RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      cmp_en = 1'b1;
    end
    chk("reset regs", 32'({dut_e(), dut_m(), dut_w()}), 32'd0);

    idle(); RegWD = 1; WA3D = 5; RST = 1'b1;
    tick();
    chk("release RegWE", 32'(RegWE), 32'd1);
    chk("release WA3E", 32'(WA3E), 32'd5);

    idle(); MemWD = 1; WA3D = 7;
    tick();
    chk("flow MemWE", 32'(MemWE), 32'd1);
    idle(); MemWriteE = 1;
    tick();
    chk("flow MemWriteM", 32'(MemWriteM), 32'd1);
    chk("flow WA3M", 32'(WA3M), 32'd7);
    idle();
    tick();
    chk("flow WA3W", 32'(WA3W), 32'd7);

    idle(); RegWD = 1; WA3D = 2;
    tick();
    chk("qual RegWE", 32'(RegWE), 32'd1);
    idle(); RegWriteE = 0;
    tick();
    chk("qual RegWriteM", 32'(RegWriteM), 32'd0);
    chk("qual WA3M", 32'(WA3M), 32'd2);

    idle(); CondD = 4'hA; WA3D = 9;
    tick();
    chk("stall CondE before", 32'(CondE), 32'hA);
    idle(); RegWriteE = 1; StallE = 1; CondD = 4'h3; WA3D = 1;
    tick();
    chk("stall1 CondE", 32'(CondE), 32'hA);
    chk("stall1 M bubble", 32'(dut_m()), 32'd0);
    CondD = 4'h5;
    tick();
    chk("stall2 CondE", 32'(CondE), 32'hA);
    chk("stall2 M bubble", 32'(dut_m()), 32'd0);
    StallE = 0; CondD = 4'h0; WA3D = 0;
    tick();
    chk("unstall M", 32'(dut_m()), 32'h89);
    chk("unstall CondE", 32'(CondE), 32'd0);
    RegWriteE = 0;
    tick();
    chk("unstall M once", 32'(dut_m()), 32'd0);
    chk("unstall WA3W", 32'(WA3W), 32'd9);

    idle(); RegWD = 1; WA3D = 6;
    tick();
    idle(); FlushE = 1; StallE = 1; BD = 1; RegWriteE = 1;
    tick();
    chk("flush BE", 32'(BE), 32'd0);
    chk("flush E bubble", 32'(dut_e()), 32'd0);
    chk("flush M bubble", 32'(dut_m()), 32'd0);

    idle(); MemtoRegD = 1; RegWD = 1; WA3D = 3;
    tick();
    idle(); RA2D = 3;
    #1;
    chk("loaduse hit", 32'(LdStallD), 32'd1);
    RA2D = 4;
    #1;
    chk("loaduse miss", 32'(LdStallD), 32'd0);

    idle(); PCSD = 1;
    tick();
    tick();
    PCSD = 0;
    #1;
    chk("pcwr pending", 32'(PCWrPendingF), 32'd1);
    RST = 1'b0;
    #1;
    chk("async pcwr", 32'(PCWrPendingF), 32'd0);
    chk("async regs", 32'({dut_e(), dut_m(), dut_w()}), 32'd0);
    tick();
    RST = 1'b1;

    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      if ($urandom_range(0, 99) == 0) begin
        #1;
        RST = 1'b0;
        #1;
        chk("rand async regs", 32'({dut_e(), dut_m(), dut_w()}), 32'd0);
        RST = 1'b1;
      end
      tick();
    end

    @(posedge CLK);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
